// File: rtl/vga_write_arbiter_if.sv
`timescale 1ns/1ps
// Pixel-write bus shared between the drawing objects and the VGA adapter.
// master: the side that drives requests and pixels (object modules / bench).
// slave:  the arbiter, which returns grant and drives the adapter-side pixel port.
interface vga_write_arbiter_if #(
   parameter int NUM_REQ     = 4,
   parameter int nX          = 10,
   parameter int nY          = 9,
   parameter int COLOR_DEPTH = 9
);
   logic [NUM_REQ-1:0]             req;
   logic [NUM_REQ*nX-1:0]          px_x;
   logic [NUM_REQ*nY-1:0]          px_y;
   logic [NUM_REQ*COLOR_DEPTH-1:0] px_color;
   logic [NUM_REQ-1:0]             px_write;
   logic [NUM_REQ-1:0]             grant;
   logic [nX-1:0]                  VGA_x;
   logic [nY-1:0]                  VGA_y;
   logic [COLOR_DEPTH-1:0]         VGA_color;
   logic                           VGA_write;
   logic                           busy;

   modport master (
      output req, px_x, px_y, px_color, px_write,
      input  grant, VGA_x, VGA_y, VGA_color, VGA_write, busy
   );

   modport slave (
      input  req, px_x, px_y, px_color, px_write,
      output grant, VGA_x, VGA_y, VGA_color, VGA_write, busy
   );
endinterface

// File: rtl/vga_write_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter for the single VGA pixel-write port. A requester owns the
// port for a whole burst (as long as it holds req), so one sprite's erase/draw
// passes are never interleaved with another's.
// Optional macro ARB_TIMEOUT_EN adds a burst watchdog (MAX_BURST cycles) and
// the timeout_err pulse output.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no owner; pick next requester after last_winner, grant it
// STREAM  | owner's pixels forwarded to VGA with one cycle of latency
// RELEASE | dead cycle: grant low, no write, owner becomes last_winner
module vga_write_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int nX          = 10,
   parameter int nY          = 9,
   parameter int COLOR_DEPTH = 9
`ifdef ARB_TIMEOUT_EN
   ,
   parameter int MAX_BURST   = 4096
`endif
) (
   input  logic               Clock,
   input  logic               Reset,
   vga_write_arbiter_if.slave bus
`ifdef ARB_TIMEOUT_EN
   ,
   output logic               timeout_err
`endif
);
   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STREAM  = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t                 state;
   logic [IDX_W-1:0]       owner;
   logic [IDX_W-1:0]       last_winner;
   logic [IDX_W-1:0]       pick_idx;
   logic                   pick_vld;
   logic [IDX_W:0]         cand;
   logic                   own_req;
   logic                   own_write;
   logic [nX-1:0]          own_x;
   logic [nY-1:0]          own_y;
   logic [COLOR_DEPTH-1:0] own_color;

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(MAX_BURST) + 1;
   logic [CNT_W-1:0] burst_cnt;
`endif

   // Select the current owner's lane out of the packed request buses.
   always_comb begin
      own_req   = bus.req[owner];
      own_write = bus.px_write[owner];
      own_x     = bus.px_x[owner*nX +: nX];
      own_y     = bus.px_y[owner*nY +: nY];
      own_color = bus.px_color[owner*COLOR_DEPTH +: COLOR_DEPTH];
   end

   // Round-robin pick: scan from the farthest candidate back to last_winner+1
   // so the nearest requesting index is the one left standing.
   always_comb begin
      pick_idx = '0;
      pick_vld = 1'b0;
      cand     = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = {1'b0, last_winner} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(NUM_REQ))
            cand = cand - (IDX_W+1)'(NUM_REQ);
         if (bus.req[cand[IDX_W-1:0]]) begin
            pick_idx = cand[IDX_W-1:0];
            pick_vld = 1'b1;
         end
      end
   end

   // Arbitration FSM with registered grant, busy and VGA outputs.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state         <= IDLE;
         owner         <= '0;
         last_winner   <= IDX_W'(NUM_REQ - 1);
         bus.grant     <= '0;
         bus.busy      <= 1'b0;
         bus.VGA_x     <= '0;
         bus.VGA_y     <= '0;
         bus.VGA_color <= '0;
         bus.VGA_write <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         burst_cnt     <= '0;
         timeout_err   <= 1'b0;
`endif
      end else begin
`ifdef ARB_TIMEOUT_EN
         timeout_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               bus.VGA_write <= 1'b0;
               if (pick_vld) begin
                  owner     <= pick_idx;
                  bus.grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                  bus.busy  <= 1'b1;
                  state     <= STREAM;
`ifdef ARB_TIMEOUT_EN
                  burst_cnt <= '0;
`endif
               end
            end

            STREAM: begin
               // Coordinates only move on real writes so they hold otherwise.
               bus.VGA_write <= own_write;
               if (own_write) begin
                  bus.VGA_x     <= own_x;
                  bus.VGA_y     <= own_y;
                  bus.VGA_color <= own_color;
               end
               if (!own_req) begin
                  bus.grant <= '0;
                  state     <= RELEASE;
               end
`ifdef ARB_TIMEOUT_EN
               else if (burst_cnt == CNT_W'(MAX_BURST - 1)) begin
                  bus.grant   <= '0;
                  timeout_err <= 1'b1;
                  state       <= RELEASE;
               end else begin
                  burst_cnt <= burst_cnt + 1'b1;
               end
`endif
            end

            RELEASE: begin
               bus.grant     <= '0;
               bus.VGA_write <= 1'b0;
               bus.busy      <= 1'b0;
               last_winner   <= owner;
               state         <= IDLE;
            end

            default: begin
               bus.grant     <= '0;
               bus.VGA_write <= 1'b0;
               bus.busy      <= 1'b0;
               state         <= IDLE;
            end
         endcase
      end
   end
endmodule
